p2s_bit_scheduler: RTL and testbench

Sequences 16-QAM slicer decisions into the serial bit stream for the downstream bit sink. Captures one {I,Q} decision pair per symbol strobe into a 2-deep symbol buffer. Emits the four bits of each symbol on consecutive sample-clock enables. Tracks frame position and flags buffer overrun and underrun, so the serializer always runs at the correct phase relative to the symbol clock.

---
 rtl/p2s_bit_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_p2s_bit_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_bit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : p2s_bit_scheduler
// Purpose  : Serializes 16-QAM slicer decisions ({Q,I}, MSB first) through a
//            2-deep symbol buffer. Tracks frame position and flags sticky
//            buffer overrun and underrun conditions.
// Revision : 1.0 - initial release
// ============================================================================
module p2s_bit_scheduler #(
    parameter int FRAME_SYMS = 16,
    parameter int SYM_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sam_clk_en,
    input  logic                 sym_clk_en,
    input  logic [1:0]           from_slicer_I,
    input  logic [1:0]           from_slicer_Q,
    input  logic                 enable,
    input  logic                 err_clear,
    output logic                 p_to_s,
    output logic                 bit_valid,
    output logic                 frame_start,
    output logic [SYM_CNT_W-1:0] sym_idx,
    output logic                 busy,
    output logic                 overrun,
    output logic                 underrun
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    localparam logic [SYM_CNT_W-1:0] c_LAST_SYM = SYM_CNT_W'(FRAME_SYMS - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [3:0]           r_buf0;      // head of the symbol buffer
    logic [3:0]           r_buf1;
    logic [1:0]           r_cnt;       // occupancy, 0..2
    logic [1:0]           r_bit_cnt;
    logic                 r_p_to_s;
    logic                 r_bit_valid;
    logic                 r_frame_start;
    logic [SYM_CNT_W-1:0] r_sym_idx;
    logic                 r_overrun;
    logic                 r_underrun;

    logic [3:0]           w_word;
    logic                 w_emit;
    logic                 w_pop;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_drop;
    logic [1:0]           w_bit_cnt_adv;
    logic                 w_to_idle;
    logic                 w_underrun_set;

    assign w_word        = {from_slicer_Q, from_slicer_I};
    assign w_emit        = ((r_state == c_RUN) || (r_state == c_DRAIN)) && sam_clk_en && (r_cnt != 2'd0);
    assign w_pop         = w_emit && (r_bit_cnt == 2'd3);
    assign w_push_req    = sym_clk_en && ((r_state == c_WAIT) || (r_state == c_RUN));
    // A full buffer still accepts a word when the head leaves in the same cycle
    assign w_push        = w_push_req && ((r_cnt != 2'd2) || w_pop);
    assign w_drop        = w_push_req && !w_push;
    assign w_bit_cnt_adv = w_emit ? (r_bit_cnt + 2'd1) : r_bit_cnt;

    // Next-state decision; every entry to IDLE flushes the buffer and frame position
    always_comb begin
        w_state_nxt    = r_state;
        w_to_idle      = 1'b0;
        w_underrun_set = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (enable) w_state_nxt = c_WAIT;
            end
            c_WAIT: begin
                if (!enable) begin
                    w_state_nxt = c_IDLE;
                    w_to_idle   = 1'b1;
                end else if ((r_cnt != 2'd0) || w_push) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (!enable) begin
                    // On a symbol boundary there is nothing left to drain
                    if (w_bit_cnt_adv == 2'd0) begin
                        w_state_nxt = c_IDLE;
                        w_to_idle   = 1'b1;
                    end else begin
                        w_state_nxt = c_DRAIN;
                    end
                end else if (sam_clk_en && (r_cnt == 2'd0)) begin
                    w_state_nxt    = c_WAIT;
                    w_underrun_set = 1'b1;
                end
            end
            default: begin
                if ((r_bit_cnt == 2'd0) || w_pop) begin
                    w_state_nxt = c_IDLE;
                    w_to_idle   = 1'b1;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Two-entry symbol buffer; r_buf0 is always the word being serialized
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf0 <= 4'h0;
            r_buf1 <= 4'h0;
            r_cnt  <= 2'd0;
        end else if (w_to_idle) begin
            r_cnt  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_buf0 <= w_word;
                    else               r_buf1 <= w_word;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd2) begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= w_word;
                    end else begin
                        r_buf0 <= w_word;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bit position within the current symbol and frame position
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= 2'd0;
            r_sym_idx <= '0;
        end else begin
            if (w_to_idle || w_underrun_set) r_bit_cnt <= 2'd0;
            else                             r_bit_cnt <= w_bit_cnt_adv;

            if (w_to_idle)                   r_sym_idx <= '0;
            else if (w_pop)                  r_sym_idx <= (r_sym_idx == c_LAST_SYM) ? '0 : r_sym_idx + 1'b1;
        end
    end

    // Registered serial output; p_to_s holds between valid pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_to_s      <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_emit) r_p_to_s <= r_buf0[2'd3 - r_bit_cnt];
            r_bit_valid   <= w_emit;
            r_frame_start <= w_emit && (r_bit_cnt == 2'd0) && (r_sym_idx == '0);
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_drop)              r_overrun  <= 1'b1;
            else if (err_clear)      r_overrun  <= 1'b0;
            if (w_underrun_set)      r_underrun <= 1'b1;
            else if (err_clear)      r_underrun <= 1'b0;
        end
    end

    assign p_to_s      = r_p_to_s;
    assign bit_valid   = r_bit_valid;
    assign frame_start = r_frame_start;
    assign sym_idx     = r_sym_idx;
    assign busy        = (r_state != c_IDLE);
    assign overrun     = r_overrun;
    assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_p2s_bit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_p2s_bit_scheduler
// Purpose  : Directed self-checking bench for p2s_bit_scheduler (FRAME_SYMS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_p2s_bit_scheduler;

    localparam int FRAME_SYMS = 4;
    localparam int SYM_CNT_W  = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 sam_clk_en = 1'b0;
    logic                 sym_clk_en = 1'b0;
    logic [1:0]           from_slicer_I = 2'b00;
    logic [1:0]           from_slicer_Q = 2'b00;
    logic                 enable = 1'b0;
    logic                 err_clear = 1'b0;
    logic                 p_to_s;
    logic                 bit_valid;
    logic                 frame_start;
    logic [SYM_CNT_W-1:0] sym_idx;
    logic                 busy;
    logic                 overrun;
    logic                 underrun;

    int n_total = 0;
    int n_bad   = 0;

    logic                 q_bit[$];
    logic                 q_fs[$];
    logic [SYM_CNT_W-1:0] q_idx[$];

    logic [3:0] t2_words [9] = '{4'h3, 4'h8, 4'hD, 4'h2, 4'h7, 4'hC, 4'h1, 4'h6, 4'hB};

    always #5 clk = ~clk;

    p2s_bit_scheduler #(
        .FRAME_SYMS (FRAME_SYMS),
        .SYM_CNT_W  (SYM_CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sam_clk_en    (sam_clk_en),
        .sym_clk_en    (sym_clk_en),
        .from_slicer_I (from_slicer_I),
        .from_slicer_Q (from_slicer_Q),
        .enable        (enable),
        .err_clear     (err_clear),
        .p_to_s        (p_to_s),
        .bit_valid     (bit_valid),
        .frame_start   (frame_start),
        .sym_idx       (sym_idx),
        .busy          (busy),
        .overrun       (overrun),
        .underrun      (underrun)
    );

    // Capture every emitted bit on the inactive edge
    always @(negedge clk) begin
        if (bit_valid) begin
            q_bit.push_back(p_to_s);
            q_fs.push_back(frame_start);
            q_idx.push_back(sym_idx);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic sam, input logic sym, input logic [3:0] w);
        sam_clk_en    = sam;
        sym_clk_en    = sym;
        from_slicer_Q = w[3:2];
        from_slicer_I = w[1:0];
        @(posedge clk);
        #1;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        err_clear  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0);
    endtask

    task automatic sam(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'h0);
    endtask

    // One symbol period: 8 cycles, bit strobes on even cycles, symbol strobe on cycle 0
    task automatic period(input logic sym, input logic [3:0] w, input int nsam);
        for (int k = 0; k < 8; k++)
            cyc(((k % 2) == 0) && ((k / 2) < nsam), sym && (k == 0), w);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        err_clear  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q_bit.delete();
        q_fs.delete();
        q_idx.delete();
    endtask

    // sel=0: serial bits, sel=1: frame_start flags; first captured bit is the MSB
    function automatic logic [63:0] qvec(input int sel, input int from, input int n);
        logic [63:0] v;
        logic        b;
        v = '0;
        for (int i = 0; i < n; i++) begin
            b = 1'b0;
            if ((from + i) < q_bit.size()) b = (sel == 0) ? q_bit[from + i] : q_fs[from + i];
            v = {v[62:0], b};
        end
        return v;
    endfunction

    // sym_idx seen on the first bit of each symbol, one nibble per symbol
    function automatic logic [63:0] idx_vec(input int nsym);
        logic [63:0] v;
        logic [3:0]  nib;
        v = '0;
        for (int k = 0; k < nsym; k++) begin
            nib = 4'hF;
            if ((4 * k) < q_idx.size()) nib = q_idx[4 * k][3:0];
            v = {v[59:0], nib};
        end
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        do_reset();
        chk("rst_p_to_s",  64'(p_to_s),      64'd0);
        chk("rst_valid",   64'(bit_valid),   64'd0);
        chk("rst_fs",      64'(frame_start), 64'd0);
        chk("rst_idx",     64'(sym_idx),     64'd0);
        chk("rst_busy",    64'(busy),        64'd0);
        chk("rst_flags",   64'({overrun, underrun}), 64'd0);

        // Three symbols, strobes phase-aligned 4:1
        enable = 1'b1;
        idle(1);
        period(1'b1, 4'b0110, 4);
        period(1'b1, 4'b0011, 4);
        period(1'b1, 4'b1001, 4);
        period(1'b0, 4'h0, 1);
        idle(2);
        chk("t1_nbits", 64'(q_bit.size()), 64'd12);
        chk("t1_bits",  qvec(0, 0, 12),    64'h639);
        chk("t1_fs",    qvec(1, 0, 12),    64'h800);
        chk("t1_idx",   idx_vec(3),        64'h012);
        chk("t1_flags", 64'({overrun, underrun}), 64'd0);
        chk("t1_busy",  64'(busy),         64'd1);

        // Nine symbols over 4-symbol frames
        do_reset();
        enable = 1'b1;
        idle(1);
        for (int s = 0; s < 9; s++) period(1'b1, t2_words[s], 4);
        period(1'b0, 4'h0, 1);
        idle(2);
        chk("t2_nbits", 64'(q_bit.size()), 64'd36);
        chk("t2_bits",  qvec(0, 0, 36),    64'h38D27C16B);
        chk("t2_fs",    qvec(1, 0, 36),    64'h800080008);
        chk("t2_idx",   idx_vec(9),        64'h012301230);

        // Overrun: three symbols with no bit strobes
        do_reset();
        enable = 1'b1;
        idle(1);
        cyc(1'b0, 1'b1, 4'b1100);
        idle(7);
        cyc(1'b0, 1'b1, 4'b1010);
        idle(7);
        chk("t3_ovr_pre", 64'(overrun), 64'd0);
        cyc(1'b0, 1'b1, 4'b0101);
        chk("t3_ovr_set", 64'(overrun), 64'd1);
        period(1'b0, 4'h0, 4);
        period(1'b0, 4'h0, 4);
        idle(2);
        chk("t3_nbits", 64'(q_bit.size()), 64'd8);
        chk("t3_bits",  qvec(0, 0, 8),     64'hCA);
        chk("t3_udr",   64'(underrun),     64'd0);
        chk("t3_ovr_hold", 64'(overrun),   64'd1);
        err_clear = 1'b1;
        idle(1);
        chk("t3_ovr_clr", 64'(overrun), 64'd0);

        // Underrun after two symbols, then resume
        do_reset();
        enable = 1'b1;
        idle(1);
        period(1'b1, 4'h5, 4);
        period(1'b1, 4'hA, 4);
        period(1'b0, 4'h0, 1);
        idle(2);
        chk("t4_nbits",   64'(q_bit.size()), 64'd8);
        chk("t4_bits",    qvec(0, 0, 8),     64'h5A);
        chk("t4_udr_pre", 64'(underrun),     64'd0);
        chk("t4_idx_pre", 64'(sym_idx),      64'd2);
        err_clear = 1'b1;
        sam(1);
        chk("t4_udr_set", 64'(underrun), 64'd1);
        chk("t4_busy",    64'(busy),     64'd1);
        chk("t4_valid",   64'(bit_valid), 64'd0);
        period(1'b1, 4'hE, 4);
        period(1'b0, 4'h0, 1);
        idle(2);
        chk("t4_nbits2", 64'(q_bit.size()), 64'd12);
        chk("t4_bits2",  qvec(0, 8, 4),     64'hE);
        chk("t4_fs",     qvec(1, 0, 12),    64'h800);
        chk("t4_idx",    idx_vec(3),        64'h012);
        chk("t4_udr_hold", 64'(underrun),   64'd1);

        // Drain: enable drops after bit 1 of the third symbol, one word buffered
        do_reset();
        enable = 1'b1;
        idle(1);
        period(1'b1, 4'h3, 4);
        period(1'b1, 4'hC, 4);
        cyc(1'b1, 1'b1, 4'h6);
        idle(1);
        sam(1);
        idle(1);
        sam(1);
        cyc(1'b0, 1'b1, 4'h9);
        enable = 1'b0;
        sam(1);
        chk("t5_busy_drain", 64'(busy), 64'd1);
        idle(1);
        sam(1);
        sam(4);
        idle(1);
        chk("t5_nbits", 64'(q_bit.size()), 64'd12);
        chk("t5_bits",  qvec(0, 0, 12),    64'h3C6);
        chk("t5_busy",  64'(busy),         64'd0);
        chk("t5_idx",   64'(sym_idx),      64'd0);
        chk("t5_ovr",   64'(overrun),      64'd0);
        enable = 1'b1;
        idle(1);
        sam(4);
        idle(1);
        chk("t5_flushed", 64'(q_bit.size()), 64'd12);
        chk("t5_udr",     64'(underrun),     64'd0);

        // Reset on bit 2 of a symbol
        do_reset();
        enable = 1'b1;
        idle(1);
        period(1'b1, 4'h9, 4);
        cyc(1'b1, 1'b1, 4'h4);
        idle(1);
        sam(1);
        idle(1);
        sam(1);
        idle(1);
        chk("t6_pre_bit", 64'(p_to_s),  64'd1);
        chk("t6_pre_idx", 64'(sym_idx), 64'd1);
        reset = 1'b1;
        sam(1);
        chk("t6_rst_outs", 64'({p_to_s, bit_valid, frame_start, busy, overrun, underrun}), 64'd0);
        chk("t6_rst_idx",  64'(sym_idx), 64'd0);
        reset  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 4'hF);
        idle(1);
        chk("t6_no_bits", 64'(q_bit.size()), 64'd6);
        enable = 1'b1;
        idle(1);
        sam(4);
        idle(1);
        chk("t6_no_bits2", 64'(q_bit.size()), 64'd6);
        period(1'b1, 4'h7, 4);
        period(1'b0, 4'h0, 1);
        idle(2);
        chk("t6_nbits", 64'(q_bit.size()), 64'd10);
        chk("t6_bits",  qvec(0, 6, 4),     64'h7);
        chk("t6_fs",    qvec(1, 6, 4),     64'h8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
